// File: rtl/offchip_mem_responder.sv
// offchip_mem_responder: dual-channel byte-wide memory slave for the `main`
// accelerator's Mout_* master port, with a preload port for input data.
// Optional feature macro: OFFCHIP_MEM_PROTO_CHECK_EN (flags oe&we collisions).
module offchip_mem_responder #(
    parameter int ADDR_W      = 10,
    parameter int BASE_ADDR   = 0,
    parameter int MEMSIZE     = 1024,
    parameter int READ_DELAY  = 2,
    parameter int WRITE_DELAY = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [1:0]            Mout_oe_ram,
    input  logic [1:0]            Mout_we_ram,
    input  logic [2*ADDR_W-1:0]   Mout_addr_ram,
    input  logic [15:0]           Mout_Wdata_ram,
    input  logic [7:0]            Mout_data_ram_size,
    output logic [15:0]           M_Rdata_ram,
    output logic [1:0]            M_DataRdy,
    input  logic                  init_we,
    input  logic [ADDR_W-1:0]     init_addr,
    input  logic [7:0]            init_data,
    output logic                  proto_err
);

    localparam int IDX_W  = (MEMSIZE > 1) ? $clog2(MEMSIZE) : 1;
    localparam int MAX_D  = (READ_DELAY > WRITE_DELAY) ? READ_DELAY : WRITE_DELAY;
    localparam int CNT_W  = (MAX_D > 1) ? $clog2(MAX_D) : 1;
    localparam int PIPE_D = READ_DELAY - 1;
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(READ_DELAY - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WRITE_DELAY - 1);

    logic [7:0]       mem [MEMSIZE];
    logic [63:0]      off [2];
    logic [IDX_W-1:0] idx [2];
    logic [1:0]       in_range;
    logic [1:0]       rd_act;
    logic [1:0]       wr_act;
    logic [7:0]       wmask [2];
    logic [7:0]       wbyte [2];
    logic [7:0]       rd_sample [2];
    logic [CNT_W-1:0] cnt [2];
    logic [CNT_W-1:0] cnt_nxt [2];
    logic [7:0]       pipe [2][PIPE_D];
    logic [63:0]      init_off;
    logic             init_hit;
    logic [IDX_W-1:0] init_idx;
`ifdef OFFCHIP_MEM_PROTO_CHECK_EN
    logic [1:0]       conflict;
`endif

    // Per-channel decode: range check, activity, counter update, write merge, ready.
    always_comb begin
        for (int unsigned c = 0; c < 2; c++) begin
            // Offset wraps to a huge value below BASE_ADDR, so one compare covers both bounds.
            off[c]      = 64'(Mout_addr_ram[c*ADDR_W +: ADDR_W]) - 64'(BASE_ADDR);
            in_range[c] = off[c] < 64'(MEMSIZE);
            idx[c]      = IDX_W'(off[c]);
        end
`ifdef OFFCHIP_MEM_PROTO_CHECK_EN
        conflict = Mout_oe_ram & Mout_we_ram;
        rd_act   = Mout_oe_ram & in_range & ~conflict;
        wr_act   = Mout_we_ram & in_range & ~conflict;
`else
        rd_act   = Mout_oe_ram & in_range;
        wr_act   = Mout_we_ram & in_range & ~Mout_oe_ram;
`endif
        for (int unsigned c = 0; c < 2; c++) begin
            if (rd_act[c])
                cnt_nxt[c] = (int'(cnt[c]) < READ_DELAY - 1) ? cnt[c] + 1'b1 : '0;
            else if (wr_act[c])
                cnt_nxt[c] = (int'(cnt[c]) < WRITE_DELAY - 1) ? cnt[c] + 1'b1 : '0;
            else
                cnt_nxt[c] = '0;
            if (Mout_data_ram_size[c*4 +: 4] >= 4'd8)
                wmask[c] = '1;
            else
                wmask[c] = 8'((9'd1 << Mout_data_ram_size[c*4 +: 4]) - 9'd1);
            wbyte[c]       = (Mout_Wdata_ram[c*8 +: 8] & wmask[c]) | (mem[idx[c]] & ~wmask[c]);
            rd_sample[c]   = in_range[c] ? mem[idx[c]] : '0;
            M_DataRdy[c]   = reset & ((rd_act[c] & (cnt[c] == RD_LAST)) |
                                      (wr_act[c] & (cnt[c] == WR_LAST)));
            M_Rdata_ram[c*8 +: 8] = pipe[c][PIPE_D-1];
        end
        init_off = 64'(init_addr) - 64'(BASE_ADDR);
        init_hit = init_we & (init_off < 64'(MEMSIZE));
        init_idx = IDX_W'(init_off);
    end

    // Storage: not reset; channel writes blocked while reset is low, preload always allowed.
    always_ff @(posedge clock) begin
        // Later assignments win: channel 1 over channel 0, preload over both.
        for (int unsigned c = 0; c < 2; c++) begin
            if (reset && wr_act[c])
                mem[idx[c]] <= wbyte[c];
        end
        if (init_hit)
            mem[init_idx] <= init_data;
    end

    // Latency counters and read-data shift pipe.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned c = 0; c < 2; c++) begin
                cnt[c] <= '0;
                for (int unsigned i = 0; i < PIPE_D; i++)
                    pipe[c][i] <= '0;
            end
        end else begin
            for (int unsigned c = 0; c < 2; c++) begin
                cnt[c]     <= cnt_nxt[c];
                pipe[c][0] <= rd_sample[c];
                for (int unsigned i = 1; i < PIPE_D; i++)
                    pipe[c][i] <= pipe[c][i-1];
            end
        end
    end

`ifdef OFFCHIP_MEM_PROTO_CHECK_EN
    // Sticky flag for a channel asserting read and write together.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            proto_err <= 1'b0;
        else if (|conflict)
            proto_err <= 1'b1;
    end
`else
    assign proto_err = 1'b0;
`endif

endmodule
